// File: rtl/epl_sio_target.sv
// Remote end of the EPL serial I/O chain: oversamples SCLK/SDI/SLE in the local
// clock domain, shifts a frame in and out, latches output pins and flags input changes.
module epl_sio_target #(
  parameter int FRAME_BITS = 32
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic        EPL_SCLK,
  input  logic        EPL_SDI,
  input  logic        EPL_SLE,
  output logic        EPL_SDO,
  output logic        EPL_INT,
  input  logic [31:0] coe_pin_in,
  output logic [31:0] coe_pin_out,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  localparam logic [7:0] FRAME_BITS_C = 8'(FRAME_BITS);

  // Synchronizers and edge-detect registers; SDI shares SCLK's depth to keep skew.
  logic        sclk_s1_q, sclk_s2_q, sclk_d_q;
  logic        sdi_s1_q, sdi_s2_q;
  logic        sle_s1_q, sle_s2_q, sle_d_q;
  logic [31:0] pin_s1_q, pin_s2_q;

  state_e      st_q, st_d;
  logic [31:0] sr_q, sr_d;
  logic [31:0] snap_q, snap_d;
  logic [7:0]  bitcnt_q, bitcnt_d;
  logic        sdo_q, sdo_d;
  logic        int_q, int_d;
  logic [31:0] pin_out_q, pin_out_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic sclk_rise, sle_rise, sle_fall;

  assign sclk_rise = sclk_s2_q & ~sclk_d_q;
  assign sle_rise  = sle_s2_q & ~sle_d_q;
  assign sle_fall  = ~sle_s2_q & sle_d_q;

  // NOTE: every flop uses a non-blocking assignment so all registers update from
  // pre-edge values; blocking here would collapse the synchronizer chain into one stage.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_d_q  <= 1'b0;
      sdi_s1_q  <= 1'b0;
      sdi_s2_q  <= 1'b0;
      sle_s1_q  <= 1'b0;
      sle_s2_q  <= 1'b0;
      sle_d_q   <= 1'b0;
      pin_s1_q  <= '0;
      pin_s2_q  <= '0;
    end else begin
      sclk_s1_q <= EPL_SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_d_q  <= sclk_s2_q;
      sdi_s1_q  <= EPL_SDI;
      sdi_s2_q  <= sdi_s1_q;
      sle_s1_q  <= EPL_SLE;
      sle_s2_q  <= sle_s1_q;
      sle_d_q   <= sle_s2_q;
      pin_s1_q  <= coe_pin_in;
      pin_s2_q  <= pin_s1_q;
    end
  end

  // NOTE: each output of this block is given a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    st_d      = st_q;
    sr_d      = sr_q;
    snap_d    = snap_q;
    bitcnt_d  = bitcnt_q;
    sdo_d     = sdo_q;
    pin_out_d = pin_out_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    int_d     = (pin_s2_q != snap_q) | int_q;

    unique case (st_q)
      ST_IDLE: begin
        if (sle_rise) begin
          sr_d     = pin_s2_q;
          snap_d   = pin_s2_q;
          sdo_d    = pin_s2_q[31];
          bitcnt_d = 8'd0;
          int_d    = 1'b0;
          st_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          sr_d     = {sr_q[30:0], sdi_s2_q};
          sdo_d    = sr_q[30];
          bitcnt_d = (bitcnt_q == 8'hFF) ? bitcnt_q : bitcnt_q + 8'd1;
        end
        // The frame is judged on the post-shift count and data, so a final SCLK
        // rise coinciding with SLE fall is still counted.
        if (sle_fall) begin
          st_d = ST_IDLE;
          if (bitcnt_d == FRAME_BITS_C) begin
            pin_out_d = sr_d;
            done_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      st_q      <= ST_IDLE;
      sr_q      <= '0;
      snap_q    <= '0;
      bitcnt_q  <= '0;
      sdo_q     <= 1'b0;
      int_q     <= 1'b0;
      pin_out_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      sr_q      <= sr_d;
      snap_q    <= snap_d;
      bitcnt_q  <= bitcnt_d;
      sdo_q     <= sdo_d;
      int_q     <= int_d;
      pin_out_q <= pin_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign EPL_SDO     = sdo_q;
  assign EPL_INT     = int_q;
  assign coe_pin_out = pin_out_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_epl_sio_target.sv
// Self-checking bench for epl_sio_target: table-driven frames, directed corner
// sequences and random frames checked against a bit-stream model of the chain.
module tb_epl_sio_target;

  localparam int FB = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, sdi, sle;
  logic        sdo, irq;
  logic [31:0] pin_in, pin_out;
  logic        done, err;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [31:0] model_out;

  epl_sio_target #(.FRAME_BITS(FB)) dut (
    .csi_MCLK_clk    (clk),
    .rsi_MRST_reset_n(rst_n),
    .EPL_SCLK        (sclk),
    .EPL_SDI         (sdi),
    .EPL_SLE         (sle),
    .EPL_SDO         (sdo),
    .EPL_INT         (irq),
    .coe_pin_in      (pin_in),
    .coe_pin_out     (pin_out),
    .frame_done      (done),
    .frame_err       (err)
  );

  always #5 clk = ~clk;

  // Pulse counters: a one-cycle pulse is seen on exactly one falling edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  typedef struct {
    logic [31:0] pin;
    logic [63:0] data;
    int          nbits;
    logic [31:0] exp_out;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Chain as the master sees it: the target's input snapshot goes out MSB first,
  // followed by whatever the master shifted in, in the order it was sent.
  function automatic logic stream_bit(input logic [31:0] pin, input logic [63:0] data,
                                      input int nbits, input int j);
    if (j < 32) return pin[31-j];
    return data[nbits-1-(j-32)];
  endfunction

  function automatic logic [63:0] exp_sdo(input logic [31:0] pin, input logic [63:0] data,
                                          input int nbits);
    logic [63:0] v = '0;
    for (int i = 0; i < nbits; i++) v[nbits-1-i] = stream_bit(pin, data, nbits, i);
    return v;
  endfunction

  // Last 32 bits of the stream, earliest at the MSB.
  function automatic logic [31:0] exp_latch(input logic [31:0] pin, input logic [63:0] data,
                                            input int nbits);
    logic [31:0] v = '0;
    for (int k = 0; k < 32; k++) v[31-k] = stream_bit(pin, data, nbits, nbits + k);
    return v;
  endfunction

  task automatic run_frame(input logic [63:0] data, input int nbits, input bit end_frame,
                           input bit fall_with_last, input logic [31:0] mid_pin,
                           input int change_at, output logic [63:0] sdo_seq,
                           output logic int_start);
    sdo_seq = '0;
    sle = 1'b1;
    clk_n(5);
    int_start = irq;
    for (int i = 0; i < nbits; i++) begin
      if (i == change_at) pin_in = mid_pin;
      sdi = data[nbits-1-i];
      clk_n(5);
      sdo_seq[nbits-1-i] = sdo;
      sclk = 1'b1;
      if (end_frame && fall_with_last && i == nbits - 1) sle = 1'b0;
      clk_n(5);
      sclk = 1'b0;
    end
    if (end_frame) begin
      if (!fall_with_last) begin
        clk_n(5);
        sle = 1'b0;
      end
      clk_n(8);
    end
  endtask

  task automatic do_frame(input string name, input logic [31:0] pin, input logic [63:0] data,
                          input int nbits, input bit fall_with_last,
                          input logic [31:0] mid_pin, input int change_at,
                          input logic [31:0] exp_out, input bit exp_done,
                          input bit exp_err, input bit exp_int);
    logic [63:0] sdo_seq;
    logic        int_start;
    int          d0, e0;
    pin_in = pin;
    clk_n(4);
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(data, nbits, 1'b1, fall_with_last, mid_pin, change_at, sdo_seq, int_start);
    check({name, "_int_clr"}, int_start, 0);
    check({name, "_sdo"}, sdo_seq, exp_sdo(pin, data, nbits));
    check({name, "_out"}, pin_out, exp_out);
    check({name, "_done"}, done_cnt - d0, exp_done);
    check({name, "_err"}, err_cnt - e0, exp_err);
    check({name, "_int"}, irq, exp_int);
  endtask

  initial begin
    vec_t        vecs[4];
    logic [31:0] pin, mid, eo, out_before;
    logic [63:0] data, dummy_seq;
    logic        sdo_before, dummy_int;
    int          nbits, change_at, d0, e0;
    bit          fwl;

    vecs[0] = '{32'hA5A5_0F0F, 64'hDEAD_BEEF, 32, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0000, 64'h1234_5678, 32, 32'h1234_5678, 1'b1, 1'b0};
    vecs[2] = '{32'hFFFF_0000, 64'h7FFF_FFFF, 31, 32'h1234_5678, 1'b0, 1'b1};
    vecs[3] = '{32'h0F0F_00FF, 64'h1_5555_AAAA, 33, 32'h1234_5678, 1'b0, 1'b1};

    rst_n = 1'b0;
    sclk = 1'b0; sdi = 1'b0; sle = 1'b0; pin_in = '0;
    clk_n(3);
    rst_n = 1'b1;
    clk_n(4);
    check("rst_out", pin_out, 0);
    check("rst_sdo", sdo, 0);
    check("rst_int", irq, 0);
    check("rst_done", done_cnt, 0);
    check("rst_err", err_cnt, 0);

    pin_in = 32'h1;
    clk_n(2);
    check("int_lat2", irq, 0);
    clk_n(1);
    check("int_lat3", irq, 1);

    for (int v = 0; v < 4; v++) begin
      do_frame($sformatf("vec%0d", v), vecs[v].pin, vecs[v].data, vecs[v].nbits, 1'b0,
               '0, -1, vecs[v].exp_out, vecs[v].exp_done, vecs[v].exp_err, 1'b0);
    end
    model_out = 32'h1234_5678;

    // SCLK activity while SLE is low must be ignored.
    out_before = pin_out;
    sdo_before = sdo;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      sdi = ~sdi;
      sclk = 1'b1; clk_n(5);
      sclk = 1'b0; clk_n(5);
    end
    check("idle_out", pin_out, out_before);
    check("idle_sdo", sdo, sdo_before);
    check("idle_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    do_frame("after_idle", 32'h3C3C_C3C3, 64'h0BAD_F00D, 32, 1'b0, '0, -1,
             32'h0BAD_F00D, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset half-way through a frame.
    pin_in = 32'h0;
    clk_n(4);
    run_frame(64'hFFFF_FFFF, 16, 1'b0, 1'b0, '0, -1, dummy_seq, dummy_int);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", pin_out, 0);
    check("mid_rst_sdo", sdo, 0);
    check("mid_rst_int", irq, 0);
    check("mid_rst_pulse", done | err, 0);
    sle = 1'b0; sclk = 1'b0;
    clk_n(2);
    rst_n = 1'b1;
    clk_n(3);
    do_frame("post_rst", 32'h0000_0000, 64'h0000_FFFF, 32, 1'b0, '0, -1,
             32'h0000_FFFF, 1'b1, 1'b0, 1'b0);

    // Final SCLK rise and SLE fall land on the same sampling edge.
    do_frame("coincide", 32'h8001_7FFE, 64'hCAFE_F00D, 32, 1'b1, '0, -1,
             32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    model_out = 32'hCAFE_F00D;

    for (int r = 0; r < 20; r++) begin
      pin   = $urandom;
      data  = {$urandom, $urandom};
      nbits = $urandom_range(30, 34);
      fwl   = 1'($urandom_range(0, 1));
      mid   = $urandom;
      change_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nbits - 1) : -1;
      eo = (nbits == FB) ? exp_latch(pin, data, nbits) : model_out;
      do_frame($sformatf("rnd%0d", r), pin, data, nbits, fwl, mid, change_at, eo,
               nbits == FB, nbits != FB, (change_at >= 0) && (mid != pin));
      model_out = eo;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
